// File: rtl/decoder_scan_param.sv
// decoder_scan_param: registered N-to-2^N one-hot decoder with up/down auto-scan; in clk,reset,enable,mode,address,load; out out,cur_address,wrap
module decoder_scan_param #(
  parameter int ADDR_WIDTH = 2,
  parameter int DWELL      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       load,
  output logic [2**ADDR_WIDTH-1:0]   out,
  output logic [ADDR_WIDTH-1:0]      cur_address,
  output logic                       wrap
);
  localparam int OUT_WIDTH = 2**ADDR_WIDTH;
  localparam int DW = DWELL > 1 ? $clog2(DWELL) : 1;
  localparam logic [1:0] M_DIRECT = 2'b00;
  localparam logic [1:0] M_UP     = 2'b01;
  localparam logic [1:0] M_HOLD   = 2'b11;
  logic [ADDR_WIDTH-1:0] cur_q, cur_d;
  logic [DW-1:0]         dwell_q, dwell_d;
  logic                  en_q, en_d, wrap_q, wrap_d;
  logic [1:0]            mode_q, mode_d;
  logic                  last;
  always_comb begin
    en_d    = enable;
    mode_d  = mode;
    cur_d   = cur_q;
    dwell_d = dwell_q;
    wrap_d  = 1'b0;
    last    = dwell_q == DW'(DWELL - 1);
    if (enable) begin
      if (mode != mode_q || mode == M_DIRECT || load) begin
        dwell_d = '0;
        cur_d   = (mode == M_DIRECT || load) ? address : cur_q;
      end else if (mode != M_HOLD) begin
        dwell_d = last ? '0 : dwell_q + DW'(1);
        cur_d   = !last ? cur_q : mode == M_UP ? cur_q + ADDR_WIDTH'(1) : cur_q - ADDR_WIDTH'(1);
        wrap_d  = last && (mode == M_UP ? &cur_q : ~|cur_q);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q   <= '0;
      dwell_q <= '0;
      en_q    <= 1'b0;
      mode_q  <= M_DIRECT;
      wrap_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      dwell_q <= dwell_d;
      en_q    <= en_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
    end
  end
  assign out         = en_q ? {{(OUT_WIDTH-1){1'b0}}, 1'b1} << cur_q : '0;
  assign cur_address = cur_q;
  assign wrap        = wrap_q;
endmodule

// File: doc/decoder_scan_param.md
Name: decoder_scan_param

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with an optional auto-scan sequencer.
- In direct mode it decodes the `address` input. In scan modes an internal address counter steps up or down through all outputs, dwelling a programmable number of cycles on each one.
- Used for row/bank selects and for multiplexed-display style strobing, where a single decoder walks all outputs in turn.

Parameters:
- ADDR_WIDTH, 2, number of address bits; number of outputs is OUT_WIDTH = 2**ADDR_WIDTH (derived localparam, not overridable).
- DWELL, 1, enabled cycles spent on each address in scan modes; legal range 1..65535. Dwell counter width is max(1, clog2(DWELL)).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  global enable; low freezes state and blanks outputs.
- mode  input  2  00 direct, 01 scan up, 10 scan down, 11 hold.
- address  input  ADDR_WIDTH  decode address (direct) or load value (scan).
- load  input  1  in scan/hold modes, loads `address` into the counter.
- out  output  OUT_WIDTH  one-hot decoded output; all zero when blanked.
- cur_address  output  ADDR_WIDTH  address currently decoded (registered).
- wrap  output  1  one-cycle pulse when the scan counter wraps.

Behaviour:
- Reset (async, any time, including mid-scan): cur_address=0, dwell_cnt=0, en_q=0, mode_q=00, wrap=0, so out=0. State is released on the first clk edge after reset deasserts.
- State registers: cur_address, dwell_cnt, en_q (registered enable), mode_q (registered mode), wrap.
- out = en_q ? (1 << cur_address) : 0.
  - out is decoded only from registers, never directly from inputs.
  - Latency from input to out is 1 cycle.
- Exactly one bit of out is high whenever en_q=1.
- Every edge: en_q <= enable; mode_q <= mode.
- Edge with enable=0:
  - cur_address, dwell_cnt and wrap hold their values, except that wrap is forced to 0.
  - load is ignored.
- Edge with enable=1, priority top-down:
  1. mode != mode_q (mode change): dwell_cnt <= 0; cur_address <= address if mode=00 or load=1, else hold; wrap <= 0.
  2. mode=00 (direct): cur_address <= address; dwell_cnt <= 0; wrap <= 0. load has no additional effect.
  3. load=1 (modes 01/10/11): cur_address <= address; dwell_cnt <= 0; wrap <= 0.
  4. mode=11 (hold): all hold; wrap <= 0.
  5. mode=01 (scan up), dwell_cnt < DWELL-1: dwell_cnt++, wrap <= 0.
  6. mode=01 (scan up), dwell_cnt == DWELL-1: dwell_cnt <= 0; cur_address <= cur_address+1 modulo OUT_WIDTH; wrap <= 1 iff cur_address was OUT_WIDTH-1.
  7. mode=10 (scan down): same as scan up but decrementing; wrap <= 1 iff cur_address was 0.
- DWELL=1: address steps every enabled cycle, and dwell_cnt stays 0.
- wrap is high for exactly one cycle per wrap, aligned with the cycle in which out shows the wrapped address.
- cur_address arithmetic is unsigned, truncated to ADDR_WIDTH bits. No out-of-range value is possible.
- X on any input while reset=1 must not propagate to outputs.

Test Plan:
- Reset/direct (ADDR_WIDTH=2): reset pulse -> out=0000; then enable=1, mode=00, address=2 -> next cycle out=0100, cur_address=2. Sweep address 0..3 -> out 0001, 0010, 0100, 1000 with 1-cycle latency.
- Scan up with wrap (ADDR_WIDTH=2, DWELL=3): from cur_address=0 -> each address held 3 cycles in order 0,1,2,3,0. wrap=1 only in the first cycle out returns to 0001.
- Scan down, load, enable gating (DWELL=1):
  - load=1 with address=1 in mode 10 -> cur_address=1, then 0, then 3 with wrap=1, then 2.
  - enable low for 4 cycles mid-scan -> out=0000 and cur_address frozen; resumes from the same address with no wrap glitch.
- Mode change and hold (DWELL=3): switch mode 01->11 mid-dwell (dwell_cnt=2) -> address held indefinitely. Switch 11->01 -> first step occurs exactly 3 cycles later.
- Async reset mid-scan (ADDR_WIDTH=3, DWELL=2): assert reset between clk edges while out=00100000 -> out=0 and wrap=0 immediately (before the next edge). After release -> cur_address=0, scan restarts from out=00000001.
